// File: rtl/locked_core_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | locked_core_pkg: shared FSM states and key-word count helper            |
// | Rev 1.0                                                                  |
// +------------------------------------------------------------------------+
package locked_core_pkg;

  typedef enum logic [1:0] {
    NOKEY = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2,
    RUN   = 2'd3
  } state_e;

  function automatic int nwords(input int key_w, input int word_w);
    return (key_w + word_w - 1) / word_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/locked_key_sreg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | locked_key_sreg: word-addressed key register with word counter          |
// | Rev 1.0                                                                  |
// +------------------------------------------------------------------------+
module locked_key_sreg
  import locked_core_pkg::*;
#(
  parameter int KEY_W  = 3071,
  parameter int WORD_W = 32,
  parameter int NW     = nwords(KEY_W, WORD_W),
  parameter int CNT_W  = $clog2(NW + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              wr_i,
  input  logic              first_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [CNT_W-1:0]  cnt_o,
  output logic [KEY_W-1:0]  key_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [KEY_W-1:0] w_mask;
  logic [KEY_W-1:0] w_data;
  logic [CNT_W-1:0] w_idx;
  logic [31:0]      w_shamt;

  // Shifting a KEY_W-wide word image drops any bits past KEY_W in the last word.
  always_comb begin
    w_idx   = first_i ? '0 : cnt_q;
    w_shamt = 32'(w_idx) * 32'(WORD_W);
    w_mask  = KEY_W'({WORD_W{1'b1}}) << w_shamt;
    w_data  = KEY_W'(data_i) << w_shamt;
    key_d   = key_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      key_d = '0;
      cnt_d = '0;
    end else if (wr_i) begin
      key_d = (key_q & ~w_mask) | w_data;
      cnt_d = w_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= '0;
      cnt_q <= '0;
    end else begin
      key_q <= key_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign key_o = key_q;

endmodule
`default_nettype wire

// File: rtl/locked_core_key_loader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | locked_core_key_loader: run-time key loading and ap_ctrl_hs gating      |
// | Optional: KEY_ZEROIZE_EN adds the key_zeroize input.                     |
// | Rev 1.0                                                                  |
// +------------------------------------------------------------------------+
module locked_core_key_loader
  import locked_core_pkg::*;
#(
  parameter int KEY_W  = 3071,
  parameter int WORD_W = 32,
  parameter int RET_W  = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [WORD_W-1:0] key_data,
  input  logic              key_last,
`ifdef KEY_ZEROIZE_EN
  input  logic              key_zeroize,
`endif
  output logic              key_loaded,
  output logic              key_err,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic [RET_W-1:0]  ap_return,
  output logic              core_ap_start,
  input  logic              core_ap_done,
  input  logic              core_ap_idle,
  input  logic              core_ap_ready,
  input  logic [RET_W-1:0]  core_ap_return,
  output logic [KEY_W-1:0]  working_key
);

  localparam int   NW       = nwords(KEY_W, WORD_W);
  localparam int   CNT_W    = $clog2(NW + 1);
  localparam logic ONE_WORD = (NW == 1);

  state_e           state_q, state_d;
  logic             key_loaded_q, key_loaded_d;
  logic             key_err_q, key_err_d;
  logic             ap_done_q;
  logic [RET_W-1:0] ap_return_q;
  logic [CNT_W-1:0] w_cnt;
  logic             w_accept, w_first, w_final, w_clr, w_zero;

`ifdef KEY_ZEROIZE_EN
  logic zpend_q;
  // A request seen while the core runs waits until the FSM is back out of RUN.
  assign w_zero = (state_q != RUN) && (key_zeroize || zpend_q);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      zpend_q <= 1'b0;
    end else if (state_q == RUN) begin
      zpend_q <= zpend_q | key_zeroize;
    end else begin
      zpend_q <= 1'b0;
    end
  end
`else
  assign w_zero = 1'b0;
`endif

  assign key_ready     = core_ap_idle && (state_q != RUN);
  assign w_accept      = key_valid && key_ready && !w_zero;
  assign w_first       = (state_q == NOKEY) || (state_q == ARMED);
  assign w_final       = w_first ? ONE_WORD : (w_cnt == CNT_W'(NW - 1));
  assign core_ap_start = ap_start && (state_q == ARMED) && !(key_valid && key_ready) && !w_zero;

  always_comb begin
    state_d      = state_q;
    key_loaded_d = key_loaded_q;
    key_err_d    = key_err_q;
    w_clr        = 1'b0;
    if (w_zero) begin
      state_d      = NOKEY;
      key_loaded_d = 1'b0;
      w_clr        = 1'b1;
    end else begin
      case (state_q)
        NOKEY, LOAD, ARMED: begin
          if (w_accept) begin
            key_loaded_d = 1'b0;
            if (w_first) key_err_d = 1'b0;
            if (key_last != w_final) begin
              key_err_d = 1'b1;
              w_clr     = 1'b1;
              state_d   = NOKEY;
            end else if (w_final) begin
              key_loaded_d = 1'b1;
              state_d      = ARMED;
            end else begin
              state_d = LOAD;
            end
          end else if ((state_q == ARMED) && core_ap_start && core_ap_ready) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (core_ap_done) state_d = ARMED;
        end
        default: state_d = NOKEY;
      endcase
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q      <= NOKEY;
      key_loaded_q <= 1'b0;
      key_err_q    <= 1'b0;
      ap_done_q    <= 1'b0;
      ap_return_q  <= '0;
    end else begin
      state_q      <= state_d;
      key_loaded_q <= key_loaded_d;
      key_err_q    <= key_err_d;
      ap_done_q    <= core_ap_done;
      if (core_ap_done) ap_return_q <= core_ap_return;
    end
  end

  locked_key_sreg #(
    .KEY_W  (KEY_W),
    .WORD_W (WORD_W),
    .NW     (NW),
    .CNT_W  (CNT_W)
  ) u_sreg (
    .clk     (ap_clk),
    .rst     (ap_rst),
    .clr_i   (w_clr),
    .wr_i    (w_accept),
    .first_i (w_first),
    .data_i  (key_data),
    .cnt_o   (w_cnt),
    .key_o   (working_key)
  );

  assign key_loaded = key_loaded_q;
  assign key_err    = key_err_q;
  assign ap_done    = ap_done_q;
  assign ap_return  = ap_return_q;
  assign ap_idle    = core_ap_idle && !ap_done_q;
  assign ap_ready   = core_ap_ready && core_ap_start;

endmodule
`default_nettype wire

// File: tb/tb_locked_core_key_loader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_locked_core_key_loader: directed self-checking bench for the loader  |
// | Rev 1.0                                                                  |
// +------------------------------------------------------------------------+
module tb_locked_core_key_loader;

  localparam int KEY_W  = 3071;
  localparam int WORD_W = 32;
  localparam int RET_W  = 32;

  logic              ap_clk = 1'b0;
  logic              ap_rst;
  logic              key_valid;
  logic              key_ready;
  logic [WORD_W-1:0] key_data;
  logic              key_last;
  logic              key_loaded;
  logic              key_err;
  logic              ap_start;
  logic              ap_done;
  logic              ap_idle;
  logic              ap_ready;
  logic [RET_W-1:0]  ap_return;
  logic              core_ap_start;
  logic              core_ap_done;
  logic              core_ap_idle;
  logic              core_ap_ready;
  logic [RET_W-1:0]  core_ap_return;
  logic [KEY_W-1:0]  working_key;
`ifdef KEY_ZEROIZE_EN
  logic              key_zeroize = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 ap_clk = ~ap_clk;

  locked_core_key_loader #(
    .KEY_W  (KEY_W),
    .WORD_W (WORD_W),
    .RET_W  (RET_W)
  ) dut (
    .ap_clk         (ap_clk),
    .ap_rst         (ap_rst),
    .key_valid      (key_valid),
    .key_ready      (key_ready),
    .key_data       (key_data),
    .key_last       (key_last),
`ifdef KEY_ZEROIZE_EN
    .key_zeroize    (key_zeroize),
`endif
    .key_loaded     (key_loaded),
    .key_err        (key_err),
    .ap_start       (ap_start),
    .ap_done        (ap_done),
    .ap_idle        (ap_idle),
    .ap_ready       (ap_ready),
    .ap_return      (ap_return),
    .core_ap_start  (core_ap_start),
    .core_ap_done   (core_ap_done),
    .core_ap_idle   (core_ap_idle),
    .core_ap_ready  (core_ap_ready),
    .core_ap_return (core_ap_return),
    .working_key    (working_key)
  );

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_key(input int n, input int last_at, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      key_valid = 1'b1;
      key_data  = base + 32'(i);
      key_last  = (i == last_at);
      tick();
    end
    key_valid = 1'b0;
    key_last  = 1'b0;
    #1;
  endtask

  initial begin
    ap_rst = 1'b1; key_valid = 1'b0; key_data = '0; key_last = 1'b0; ap_start = 1'b0;
    core_ap_done = 1'b0; core_ap_idle = 1'b0; core_ap_ready = 1'b0; core_ap_return = '0;
    tick(); tick();
    check("rst_key_ready_busy", key_ready, 1'b0);
    check("rst_ap_idle_busy", ap_idle, 1'b0);
    core_ap_idle = 1'b1; #1;
    check("rst_key_ready", key_ready, 1'b1);
    check("rst_ap_idle", ap_idle, 1'b1);
    check("rst_key_loaded", key_loaded, 1'b0);
    check("rst_key_err", key_err, 1'b0);
    check("rst_ap_done", ap_done, 1'b0);
    check("rst_ap_return", ap_return, 32'h0);
    check("rst_working_key_or", |working_key, 1'b0);
    check("rst_core_start", core_ap_start, 1'b0);

    // Start held in NOKEY must never reach the core.
    ap_rst = 1'b0; ap_start = 1'b1; core_ap_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("nokey_core_start", core_ap_start, 1'b0);
    end
    check("nokey_ap_ready", ap_ready, 1'b0);
    core_ap_ready = 1'b0;

    load_key(96, 95, 32'hA5A5_0000);
    check("full_key_loaded", key_loaded, 1'b1);
    check("full_key_err", key_err, 1'b0);
    check("full_word0", working_key[31:0], 32'hA5A5_0000);
    check("full_word1", working_key[63:32], 32'hA5A5_0001);
    check("full_top_trunc", working_key[3070:3040], 31'h25A5_005F);
    check("armed_core_start", core_ap_start, 1'b1);
    check("armed_ap_ready_norm", ap_ready, 1'b0);

    core_ap_ready = 1'b1; #1;
    check("armed_ap_ready", ap_ready, 1'b1);
    tick();
    core_ap_ready = 1'b0; ap_start = 1'b0; core_ap_idle = 1'b0; #1;
    check("run_key_ready", key_ready, 1'b0);
    tick(); tick();
    core_ap_done = 1'b1; core_ap_return = 32'h1234_5678;
    #1;
    check("run_ap_done_early", ap_done, 1'b0);
    tick();
    core_ap_done = 1'b0; core_ap_return = 32'hDEAD_BEEF; core_ap_idle = 1'b1; #1;
    check("done_pulse", ap_done, 1'b1);
    check("done_return", ap_return, 32'h1234_5678);
    check("done_ap_idle", ap_idle, 1'b0);
    tick();
    check("done_pulse_end", ap_done, 1'b0);
    check("done_return_hold", ap_return, 32'h1234_5678);
    check("done_ap_idle_back", ap_idle, 1'b1);
    check("done_key_loaded", key_loaded, 1'b1);

    // Key word and start together in ARMED: the word wins.
    ap_start = 1'b1; key_valid = 1'b1; key_data = 32'h1111_1111; key_last = 1'b0; #1;
    check("coll_core_start", core_ap_start, 1'b0);
    check("coll_key_ready", key_ready, 1'b1);
    tick();
    key_valid = 1'b0; #1;
    check("coll_key_loaded", key_loaded, 1'b0);
    check("coll_word0", working_key[31:0], 32'h1111_1111);
    check("coll_load_start", core_ap_start, 1'b0);

    // Nine more words with last on overall word 10.
    load_key(9, 8, 32'hB000_0000);
    check("early_key_err", key_err, 1'b1);
    check("early_key_loaded", key_loaded, 1'b0);
    check("early_key_zero", |working_key, 1'b0);
    check("early_core_start", core_ap_start, 1'b0);

    ap_start = 1'b0;
    load_key(40, -1, 32'hC000_0000);
    check("mid_err_cleared", key_err, 1'b0);
    check("mid_word39", working_key[39*32 +: 32], 32'hC000_0027);
    ap_rst = 1'b1; tick(); ap_rst = 1'b0; #1;
    check("midrst_key_zero", |working_key, 1'b0);
    check("midrst_key_loaded", key_loaded, 1'b0);

    load_key(96, -1, 32'h5000_0000);
    check("nolast_key_err", key_err, 1'b1);
    check("nolast_key_zero", |working_key, 1'b0);

    load_key(96, 95, 32'hA5A5_0000);
    check("reload_key_loaded", key_loaded, 1'b1);
    check("reload_key_err", key_err, 1'b0);
    check("reload_word40", working_key[40*32 +: 32], 32'hA5A5_0028);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
